move_input_conditioner: RTL and testbench

Conditions the four raw board push-buttons into clean, glitch-free direction levels and generates the slow `move_clk` that paces block movement in the maze controller. It sits directly upstream of the maze controller and drives its `Up`, `Down`, `Left`, `Right` and `move_clk` inputs. The direction outputs are one-hot with a fixed priority and change only at `move_clk` falling edges, so the maze controller samples a stable value at every rising edge.

---
 rtl/maze_pkg.sv | 28 ++
 rtl/button_debouncer.sv | 79 +++++++
 rtl/move_input_conditioner.sv | 66 ++++++
 tb/tb_move_input_conditioner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze input path: debouncer state encoding,
// direction bit positions and the fixed-priority direction encoder.
package maze_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RISE = 4'b0010,
    HIGH = 4'b0100,
    FALL = 4'b1000
  } db_state_e;

  localparam int DIR_R = 3;
  localparam int DIR_L = 2;
  localparam int DIR_U = 1;
  localparam int DIR_D = 0;

  // Right > Left > Up > Down; nothing held gives all zeros.
  function automatic logic [3:0] prio_onehot(input logic [3:0] lvl);
    logic [3:0] onehot;
    onehot = '0;
    if (lvl[DIR_R])      onehot[DIR_R] = 1'b1;
    else if (lvl[DIR_L]) onehot[DIR_L] = 1'b1;
    else if (lvl[DIR_U]) onehot[DIR_U] = 1'b1;
    else if (lvl[DIR_D]) onehot[DIR_D] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-FF synchronizer followed by a four-state debounce FSM
// whose accepted level is presented from a register.
module button_debouncer
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic Reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;

  // The cycle that enters RISE/FALL already counts as the first stable cycle.
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= (state_q == HIGH) || (state_q == FALL);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (sync2_q) state_q <= RISE;
        end
        RISE: begin
          if (!sync2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_d == CNT_LAST) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HIGH: begin
          cnt_q <= '0;
          if (!sync2_q) state_q <= FALL;
        end
        FALL: begin
          if (sync2_q) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else if (cnt_d == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/move_input_conditioner.sv
// Debounces the four direction buttons, generates move_clk and latches a
// one-hot direction on each move_clk falling edge for the maze controller.
module move_input_conditioner
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MOVE_HALF       = 2_500_000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic       move_clk,
  output logic       Up,
  output logic       Down,
  output logic       Left,
  output logic       Right,
  output logic [3:0] held
);

  localparam int MV_W = (MOVE_HALF > 2) ? $clog2(MOVE_HALF) : 1;
  localparam logic [MV_W-1:0] MV_LAST = MV_W'(MOVE_HALF - 1);

  logic [3:0]      held_lvl;
  logic [3:0]      dir_d;
  logic [3:0]      dir_q;
  logic [MV_W-1:0] mv_cnt_q;
  logic            move_clk_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk(clk), .Reset(Reset), .btn_i(BtnR), .level_o(held_lvl[DIR_R]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk(clk), .Reset(Reset), .btn_i(BtnL), .level_o(held_lvl[DIR_L]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
    .clk(clk), .Reset(Reset), .btn_i(BtnU), .level_o(held_lvl[DIR_U]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
    .clk(clk), .Reset(Reset), .btn_i(BtnD), .level_o(held_lvl[DIR_D]));

  assign dir_d = prio_onehot(held_lvl);

  // Directions load only as move_clk falls, giving the consumer a full
  // low phase of setup before it samples on the rising edge.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      mv_cnt_q   <= '0;
      move_clk_q <= 1'b0;
      dir_q      <= '0;
    end else if (mv_cnt_q == MV_LAST) begin
      mv_cnt_q   <= '0;
      move_clk_q <= ~move_clk_q;
      if (move_clk_q) dir_q <= dir_d;
    end else begin
      mv_cnt_q <= mv_cnt_q + 1'b1;
    end
  end

  assign move_clk = move_clk_q;
  assign Right    = dir_q[DIR_R];
  assign Left     = dir_q[DIR_L];
  assign Up       = dir_q[DIR_U];
  assign Down     = dir_q[DIR_D];
  assign held     = held_lvl;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with DEBOUNCE_CYCLES=4, MOVE_HALF=8.
module tb_move_input_conditioner;

  logic       clk = 1'b0;
  logic       Reset;
  logic       BtnU, BtnD, BtnL, BtnR;
  logic       move_clk;
  logic       Up, Down, Left, Right;
  logic [3:0] held;

  int checks = 0;
  int errors = 0;

  move_input_conditioner #(.DEBOUNCE_CYCLES(4), .MOVE_HALF(8)) dut (
    .clk(clk), .Reset(Reset),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .move_clk(move_clk), .Up(Up), .Down(Down), .Left(Left), .Right(Right),
    .held(held)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fall(output bit ok);
    logic p;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      p = move_clk;
      tick();
      if (p && !move_clk) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rise(output bit ok);
    logic p;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      p = move_clk;
      tick();
      if (!p && move_clk) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    Reset = 1'b1; BtnU = 0; BtnD = 0; BtnL = 0; BtnR = 0;
    repeat (3) tick();
    checks++;
    if ({move_clk, Right, Left, Up, Down, held} !== 9'b0) begin
      errors++; $display("FAIL reset_state got %b want 000000000", {move_clk, Right, Left, Up, Down, held});
    end
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (move_clk) break; end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL first_rise got %0d want 8", n); end
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (!move_clk) break; end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL high_phase got %0d want 8", n); end
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (move_clk) break; end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL low_phase got %0d want 8", n); end

    BtnR = 1'b1;
    repeat (24) tick();
    checks++;
    if ({held, Right} !== 5'b10001) begin
      errors++; $display("FAIL pre_reset_active got %b want 10001", {held, Right});
    end
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if ({move_clk, Right, Left, Up, Down, held} !== 9'b0) begin
      errors++; $display("FAIL async_reset got %b want 000000000", {move_clk, Right, Left, Up, Down, held});
    end
    BtnR = 1'b0;
    tick();
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (move_clk) break; end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL rise_after_reset got %0d want 8", n); end
  endtask

  task automatic test_clean_press();
    bit ok;
    BtnR = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) begin
        checks++;
        if (held[3] !== 1'b0) begin errors++; $display("FAIL held_r_early got %b want 0", held[3]); end
      end
    end
    checks++;
    if (held !== 4'b1000) begin errors++; $display("FAIL held_r_at7 got %b want 1000", held); end
    wait_fall(ok);
    checks++;
    if (!ok || {Right, Left, Up, Down} !== 4'b1000) begin
      errors++; $display("FAIL right_dir got %b ok %0d want 1000", {Right, Left, Up, Down}, ok);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    logic seen_held, seen_up;
    BtnR = 1'b0;
    repeat (40) tick();
    pat = 6'b011011;
    seen_held = 1'b0; seen_up = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      BtnU = pat[i];
      tick();
      seen_held |= held[1]; seen_up |= Up;
    end
    BtnU = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen_held |= held[1]; seen_up |= Up;
    end
    checks++;
    if (seen_held !== 1'b0) begin errors++; $display("FAIL bounce_held got %b want 0", seen_held); end
    checks++;
    if (seen_up !== 1'b0) begin errors++; $display("FAIL bounce_up got %b want 0", seen_up); end
  endtask

  task automatic test_priority();
    bit ok;
    int n;
    BtnD = 1'b1; BtnL = 1'b1;
    repeat (7) tick();
    checks++;
    if (held !== 4'b0101) begin errors++; $display("FAIL held_dl got %b want 0101", held); end
    wait_fall(ok);
    checks++;
    if (!ok || {Right, Left, Up, Down} !== 4'b0100) begin
      errors++; $display("FAIL prio_left got %b ok %0d want 0100", {Right, Left, Up, Down}, ok);
    end
    BtnL = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (!held[2]) break; end
    checks++;
    if (n !== 7) begin errors++; $display("FAIL release_latency got %0d want 7", n); end
    wait_fall(ok);
    checks++;
    if (!ok || {Right, Left, Up, Down} !== 4'b0001) begin
      errors++; $display("FAIL prio_down got %b ok %0d want 0001", {Right, Left, Up, Down}, ok);
    end
  endtask

  task automatic test_stability();
    bit ok;
    logic prev_r, prev_m;
    int changes, viol;
    BtnD = 1'b0; BtnR = 1'b1;
    repeat (40) tick();
    wait_rise(ok);
    checks++;
    if (!ok || {held, Right} !== 5'b10001) begin
      errors++; $display("FAIL stab_pre got %b ok %0d want 10001", {held, Right}, ok);
    end
    BtnR = 1'b0;
    changes = 0; viol = 0;
    for (int t = 1; t <= 40; t++) begin
      prev_r = Right; prev_m = move_clk;
      tick();
      if (Right !== prev_r) begin
        changes++;
        if (!(prev_m && !move_clk)) viol++;
      end
      if (t == 8) BtnR = 1'b1;
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL stab_edge got %0d off-edge changes want 0", viol); end
    checks++;
    if (changes !== 2) begin errors++; $display("FAIL stab_toggles got %0d want 2", changes); end
  endtask

  task automatic test_release();
    bit ok;
    BtnU = 0; BtnD = 0; BtnL = 0; BtnR = 0;
    wait_fall(ok);
    checks++;
    if (!ok || {Right, Left, Up, Down, held} !== 8'b0) begin
      errors++; $display("FAIL release_all got %b ok %0d want 00000000", {Right, Left, Up, Down, held}, ok);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_priority();
    test_stability();
    test_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
